// File: rtl/vpu_sram_rd_arbiter.sv
// Round-robin arbiter sharing one SRAM read port among N_PORTS VPU source ports.
// Optional macro VPU_SRAM_ARB_RDATA_REG_EN registers rvalid_o/rdata_o (+1 cycle latency).

module vpu_sram_rd_arbiter_port #(
  parameter int ADDR_WIDTH = 10,
  parameter int IDW        = 2,
  parameter int PORT_ID    = 0
) (
  input  logic                  issue,
  input  logic [IDW-1:0]        win,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  last_vld,
  input  logic [IDW-1:0]        last_id,
  output logic                  gnt,
  output logic                  rvalid,
  output logic [ADDR_WIDTH-1:0] addr_sel
);
  assign gnt      = issue && (win == IDW'(PORT_ID));
  assign rvalid   = last_vld && (last_id == IDW'(PORT_ID));
  assign addr_sel = gnt ? addr : '0;
endmodule

module vpu_sram_rd_arbiter #(
  parameter int N_PORTS    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [N_PORTS-1:0]            req_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] addr_i,
  output logic [N_PORTS-1:0]            gnt_o,
  output logic [N_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          busy_o,
  output logic                          sram_rden_o,
  output logic [ADDR_WIDTH-1:0]         sram_raddr_o,
  input  logic [DATA_WIDTH-1:0]         sram_rdata_i
);
  localparam int IDW    = $clog2(N_PORTS);
  localparam int STAGES = RD_LATENCY - 1;

  logic [IDW-1:0]                       ptr;
  logic [IDW-1:0]                       win;
  logic                                 found;
  logic                                 issue;
  logic [2*N_PORTS-1:0]                 req_rot;
  logic [STAGES:0]                      vld_pipe;
  logic [STAGES:0][IDW-1:0]             id_pipe;
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   addr_v;
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   addr_sel;
  logic [N_PORTS-1:0]                   rvalid_raw;
  logic                                 last_vld;

  assign addr_v = addr_i;

  // Rotate the doubled request vector so bit i is port (ptr+i) mod N_PORTS.
  assign req_rot = {req_i, req_i} >> ptr;

  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        win   = (int'(ptr) + i >= N_PORTS) ? IDW'(int'(ptr) + i - N_PORTS) : IDW'(int'(ptr) + i);
      end
    end
  end

  // Gating with rst_n keeps the combinational outputs quiet while reset is held.
  assign issue       = rst_n & ~flush_i & found;
  assign sram_rden_o = issue;
  assign last_vld    = vld_pipe[STAGES] & ~flush_i;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    vpu_sram_rd_arbiter_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .IDW        (IDW),
      .PORT_ID    (k)
    ) u_port (
      .issue    (issue),
      .win      (win),
      .addr     (addr_v[k]),
      .last_vld (last_vld),
      .last_id  (id_pipe[STAGES]),
      .gnt      (gnt_o[k]),
      .rvalid   (rvalid_raw[k]),
      .addr_sel (addr_sel[k])
    );
  end

  always_comb begin
    sram_raddr_o = '0;
    for (int k = 0; k < N_PORTS; k++) sram_raddr_o = sram_raddr_o | addr_sel[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      id_pipe[0] <= win;
      for (int s = 1; s <= STAGES; s++) id_pipe[s] <= id_pipe[s-1];
      if (flush_i) begin
        ptr      <= '0;
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= issue;
        for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        if (issue) ptr <= (win == IDW'(N_PORTS - 1)) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef VPU_SRAM_ARB_RDATA_REG_EN
  logic [N_PORTS-1:0]    rv_q;
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= '0;
      rd_q <= '0;
    end else begin
      rv_q <= flush_i ? '0 : rvalid_raw;
      rd_q <= (|rvalid_raw) ? sram_rdata_i : '0;
    end
  end

  assign rvalid_o = flush_i ? '0 : rv_q;
  assign rdata_o  = (|rvalid_o) ? rd_q : '0;
  assign busy_o   = (|vld_pipe) | (|rv_q);
`else
  assign rvalid_o = rvalid_raw;
  assign rdata_o  = (|rvalid_raw) ? sram_rdata_i : '0;
  assign busy_o   = |vld_pipe;
`endif

endmodule

// File: tb/tb_vpu_sram_rd_arbiter.sv
// Scoreboard bench for vpu_sram_rd_arbiter (RD_LATENCY=3); honours VPU_SRAM_ARB_RDATA_REG_EN.

module tb_vpu_sram_rd_arbiter;
  localparam int N   = 3;
  localparam int AW  = 10;
  localparam int DW  = 256;
  localparam int LAT = 3;
`ifdef VPU_SRAM_ARB_RDATA_REG_EN
  localparam int RLAT = LAT + 1;
`else
  localparam int RLAT = LAT;
`endif

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic [N-1:0]      req_i;
  logic [N*AW-1:0]   addr_i;
  logic [N-1:0]      gnt_o;
  logic [N-1:0]      rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              busy_o;
  logic              sram_rden_o;
  logic [AW-1:0]     sram_raddr_o;
  logic [DW-1:0]     sram_rdata_i;

  vpu_sram_rd_arbiter #(
    .N_PORTS    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .sram_rden_o  (sram_rden_o),
    .sram_raddr_o (sram_raddr_o),
    .sram_rdata_i (sram_rdata_i)
  );

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
    int          due;
  } exp_t;

  exp_t               sb[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  int                 ptr_m = 0;
  logic [N-1:0][AW-1:0] paddr;
  logic [AW-1:0]      apipe [LAT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    logic [31:0] w;
    w = ({22'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    return {8{w}};
  endfunction

  // SRAM model: data for the address sampled LAT edges earlier
  always @(posedge clk) begin
    apipe[0] <= sram_raddr_o;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign sram_rdata_i = mem_f(apipe[LAT-1]);

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = r >> ((p + i) % N);
      if (t[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] req, input logic fl);
    int            pick;
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [AW-1:0] ea;
    logic [DW-1:0] erd;
    exp_t          e;
    req_i   = req;
    flush_i = fl;
    addr_i  = paddr;
    @(negedge clk);
    pick = rr_pick(req, ptr_m);
    eg = '0;
    ea = '0;
    if (!fl && pick >= 0) begin
      eg = N'(1) << pick;
      ea = paddr[pick];
    end
    check("gnt", gnt_o, eg);
    check("rden", sram_rden_o, (|req) & ~fl);
    check("raddr", sram_raddr_o, ea);
    check("busy", busy_o, sb.size() != 0);
    erv = '0;
    erd = '0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      if (!fl) begin
        erv = N'(1) << sb[0].port;
        erd = mem_f(sb[0].addr);
      end
      void'(sb.pop_front());
    end
    check("rvalid", rvalid_o, erv);
    if (erv != '0) check("rdata", rdata_o, erd);
    if (fl) begin
      sb.delete();
      ptr_m = 0;
    end else if (pick >= 0) begin
      e.port = pick;
      e.addr = paddr[pick];
      e.due  = cyc + RLAT;
      sb.push_back(e);
      ptr_m = (pick + 1) % N;
      paddr[pick] = paddr[pick] + 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, gnt_o, '0);
    check({tag, "_rvalid"}, rvalid_o, '0);
    check({tag, "_rdata"}, rdata_o, '0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_rden"}, sram_rden_o, 1'b0);
    check({tag, "_raddr"}, sram_raddr_o, '0);
  endtask

  task automatic drain();
    repeat (RLAT + 1) step('0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    req_i   = '1;
    for (int k = 0; k < N; k++) paddr[k] = AW'(16 * (k + 1));
    addr_i  = paddr;
    #3;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round robin with all ports requesting
    repeat (6) step(3'b111, 1'b0);
    drain();

    // pointer: grant port 2, then 011 must go to port 0
    step(3'b100, 1'b0);
    step(3'b011, 1'b0);
    drain();

    // single read latency / busy window
    step(3'b010, 1'b0);
    drain();

    // flush at the cycle the first response is due
    repeat (RLAT) step(3'b111, 1'b0);
    step(3'b111, 1'b1);
    step(3'b011, 1'b0);
    // port 1 withdraws while port 0 was granted
    step(3'b101, 1'b0);
    step(3'b101, 1'b0);
    drain();

    repeat (80) step(N'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
    drain();

    // asynchronous reset mid-traffic
    repeat (2) step(3'b111, 1'b0);
    req_i = 3'b111;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    sb.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(3'b111, 1'b0);
    drain();
    step('0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vpu_sram_rd_arbiter.md
# vpu_sram_rd_arbiter

- Shares one single-ported operand SRAM read port among `N_PORTS` VPU source-port requesters (src0/src1/src2 for up to ternary ops).
- Each cycle it selects one request with a round-robin policy and drives the SRAM read port.
- It tracks each issued read through a fixed-latency tag pipeline and returns the data to the requester that issued it.
- It sits between the source-port controllers and the shared SRAM read interface, under control of the VPU controller's reset command.

## Interface
Parameters:
- `N_PORTS`, 3: number of requesters; legal range 2..8.
- `ADDR_WIDTH`, 10: SRAM word address width.
- `DATA_WIDTH`, 256: SRAM read data width.
- `RD_LATENCY`, 1: SRAM cycles from `sram_rden_o` to valid `sram_rdata_i`; legal range 1..4.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `flush_i`, in, 1: controller reset command; discards everything in flight.
- `req_i`, in, `N_PORTS`: per-port read request, level.
- `addr_i`, in, `N_PORTS*ADDR_WIDTH`: per-port address; port k occupies bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `gnt_o`, out, `N_PORTS`: one-hot grant, combinational.
- `rvalid_o`, out, `N_PORTS`: one-hot read-data valid, identifying the owner.
- `rdata_o`, out, `DATA_WIDTH`: read data, broadcast to all ports.
- `busy_o`, out, 1: at least one read is in flight.
- `sram_rden_o`, out, 1: SRAM read enable.
- `sram_raddr_o`, out, `ADDR_WIDTH`: SRAM read address.
- `sram_rdata_i`, in, `DATA_WIDTH`: SRAM read data.

## Operation
- **Handshake.** A requester raises `req_i[k]` and holds `addr_i` stable until the cycle in which `req_i[k] & gnt_o[k]`; that cycle is one accepted read. It may hold `req_i[k]` high for back-to-back reads, with a new address each accepted cycle.
- **Arbitration.**
  - Pointer `ptr` (`$clog2(N_PORTS)` bits, reset 0).
  - The winner is the first asserted `req_i` found searching `ptr`, `ptr+1`, … modulo `N_PORTS`.
  - After a grant to port k, `ptr <= (k+1) mod N_PORTS`. With no grant, `ptr` holds.
  - At most one grant per cycle; no request is starved longer than `N_PORTS-1` grants.
- **Issue.**
  - `sram_rden_o = |req_i & ~flush_i`.
  - `sram_raddr_o` = the winner's address; it is 0 when there is no grant.
- **Tag pipeline.**
  - `RD_LATENCY` stages of {valid, port id}.
  - Stage 0 loads {`sram_rden_o`, winner}; all stages shift every cycle; there is no back-pressure.
- **Return.**
  - When the last stage is valid with id k: `rvalid_o[k]=1` and `rdata_o=sram_rdata_i` in that cycle.
  - Otherwise `rvalid_o=0` and `rdata_o` is don't-care; drive 0.
- **Busy.** `busy_o` = OR of all stage valids, plus the registered output stage valid when that stage is present (see Configuration).
- **Flush.**
  - While `flush_i=1`: `gnt_o=0`, `sram_rden_o=0`, `rvalid_o=0`.
  - At the next edge all stage valids clear and `ptr` returns to 0; in-flight data is dropped.
- **Reset.** Async-clears `ptr` and all stage valids. Outputs during reset: `gnt_o=0`, `rvalid_o=0`, `rdata_o=0`, `busy_o=0`, `sram_rden_o=0`, `sram_raddr_o=0`.

## Timing
- Grant is combinational; zero-cycle request-to-grant.
- Accepted in cycle T → `rvalid_o` asserted in cycle T+`RD_LATENCY`, or T+`RD_LATENCY`+1 with the macro defined (see Configuration).
- Sustained throughput: one read per cycle across all ports.
- `flush_i` in the same cycle as a last-stage valid suppresses that `rvalid_o`.
- A new request in the cycle after flush deassertion is granted normally, starting from `ptr=0`.
- A requester dropping `req_i[k]` before its grant is legal; nothing is issued for it.
- Asserting `rst_n` low mid-operation clears all state asynchronously; no response is ever produced for pre-reset reads.

## Configuration
- **`VPU_SRAM_ARB_RDATA_REG_EN`**
  - Defined:
    - Adds one output register: `rvalid_o` and `rdata_o` come from flops, adding 1 cycle of latency.
    - The register's valid bit is async-reset and cleared by `flush_i`.
    - The register's valid bit counts toward `busy_o`.
  - Undefined: `rvalid_o` and `rdata_o` are combinational from the last tag stage and `sram_rdata_i`.

## Test plan
- **Reset.** Hold `rst_n=0` with `req_i=3'b111` → all outputs 0. Release → `gnt_o=3'b001` the same cycle.
- **Round robin.** `req_i=3'b111` held for 6 cycles, addresses 0x10/0x20/0x30 → grants 001,010,100,001,010,100. With `RD_LATENCY=1`, `rvalid_o` follows one cycle later with matching `sram_rdata_i`.
- **Pointer.** Grant port 2, then `req_i=3'b011` → port 0 is granted, not port 1.
- **Latency.** `RD_LATENCY=3`, a single read from port 1 at cycle 5 → `rvalid_o=3'b010` at cycle 8 only, 9 with the macro. `busy_o` is high for cycles 6-8.
- **Flush.** Back-to-back reads with `flush_i` pulsed at the cycle the first response is due → no `rvalid_o` from any pre-flush read. `busy_o=0` the next cycle; `ptr=0`.
- **Request withdrawn.** `req_i[1]` dropped while port 0 is granted → no SRAM access is issued for port 1; the next grant goes to the next requester.
